// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, FSM states,
// opcode classes and the bundle of datapath strobes.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {S_F0, S_F1, S_MW, S_F2, S_EX, S_HALT} state_e;

  typedef enum logic [4:0] {
    C_ALU_R, C_ALU_I, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR, C_JR,
    C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } op_class_e;

  typedef struct packed {
    logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, read, outport_in;
    logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic ram_read, ram_write, gra, grb, grc, rin, rout, baout, con_in, inc_pc;
  } strobes_t;

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier: instruction class plus index of its last EX step.
module opcode_class_decode
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class,
  output logic [2:0] last_step
);

  always_comb begin
    op_class  = C_ILL;
    last_step = 3'd0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        op_class = C_ALU_R; last_step = 3'd2;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin op_class = C_ALU_I;  last_step = 3'd2; end
      OP_NEG, OP_NOT:           begin op_class = C_UNARY;  last_step = 3'd1; end
      OP_MUL, OP_DIV:           begin op_class = C_MULDIV; last_step = 3'd3; end
      OP_LD:                    begin op_class = C_LD;     last_step = 3'd4; end
      OP_LDI:                   begin op_class = C_LDI;    last_step = 3'd2; end
      OP_ST:                    begin op_class = C_ST;     last_step = 3'd4; end
      OP_BR:                    begin op_class = C_BR;     last_step = 3'd3; end
      OP_JR:                    op_class = C_JR;
      OP_JAL:                   begin op_class = C_JAL;    last_step = 3'd1; end
      OP_IN:                    op_class = C_IN;
      OP_OUT:                   op_class = C_OUT;
      OP_MFHI:                  op_class = C_MFHI;
      OP_MFLO:                  op_class = C_MFLO;
      OP_NOP:                   op_class = C_NOP;
      OP_HALT:                  op_class = C_HALT;
      default:                  op_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Mini SRC control sequencer: fetch, optional memory wait, decode and
// T-step execution, driving the datapath strobes as Moore outputs.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] opcode,
  input  logic       CON_out,
  input  logic       stop,
  output logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, Read, OutPort_in,
  output logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
  output logic RAM_read, RAM_write,
  output logic Gra, Grb, Grc, Rin, Rout, BAout,
  output logic CON_in,
  output logic IncPC,
  output logic run,
  output logic illegal
);

  localparam logic [1:0] MW_LOAD = 2'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [1:0] wait_q, wait_d;
  logic       ret_ex_q, ret_ex_d;
  logic       stop_q, stop_d;
  logic       run_q, run_d;
  op_class_e  op_class;
  logic [2:0] last_step;
  state_e     end_state;
  strobes_t   s;

  opcode_class_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .last_step(last_step)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    wait_d    = wait_q;
    ret_ex_d  = ret_ex_q;
    stop_d    = stop_q | stop;
    end_state = (stop_q | stop) ? S_HALT : S_F0;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: begin
        if (MEM_WAIT == 0) state_d = S_F2;
        else begin state_d = S_MW; wait_d = MW_LOAD; ret_ex_d = 1'b0; end
      end
      S_MW: begin
        // ret_ex_q selects the caller: instruction fetch or ld step 3
        if (wait_q == 2'd1) begin
          state_d = ret_ex_q ? S_EX : S_F2;
          if (ret_ex_q) step_d = step_q + 3'd1;
        end else wait_d = wait_q - 2'd1;
      end
      S_F2: begin
        step_d = '0;
        if (op_class == C_NOP)       state_d = end_state;
        else if (op_class == C_HALT) state_d = S_HALT;
        else                         state_d = S_EX;
      end
      S_EX: begin
        if (step_q == last_step) begin
          state_d = end_state; step_d = '0;
        end else if (op_class == C_LD && step_q == 3'd3 && MEM_WAIT != 0) begin
          state_d = S_MW; wait_d = MW_LOAD; ret_ex_d = 1'b1;
        end else step_d = step_q + 3'd1;
      end
      default: state_d = S_HALT;
    endcase
    run_d = (state_d != S_HALT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_F0; step_q <= '0; wait_q <= '0;
      ret_ex_q <= 1'b0; stop_q <= 1'b0; run_q <= 1'b1;
    end else begin
      state_q <= state_d; step_q <= step_d; wait_q <= wait_d;
      ret_ex_q <= ret_ex_d; stop_q <= stop_d; run_q <= run_d;
    end
  end

  always_comb begin
    s = '0;
    illegal = 1'b0;
    if (!clr) begin
      case (state_q)
        S_F0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1; end
        S_F1: begin
          s.zlow_out = 1'b1; s.pc_in = 1'b1; s.ram_read = 1'b1;
          if (MEM_WAIT == 0) begin s.read = 1'b1; s.mdr_in = 1'b1; end
        end
        S_MW: begin
          s.ram_read = 1'b1;
          if (wait_q == 2'd1) begin s.read = 1'b1; s.mdr_in = 1'b1; end
        end
        S_F2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
        S_EX: begin
          case (op_class)
            C_ALU_R, C_ALU_I: case (step_q)
              3'd0: begin s.grb = 1'b1; s.rout = 1'b1; s.y_in = 1'b1; end
              3'd1: begin
                if (op_class == C_ALU_I) s.c_out = 1'b1;
                else begin s.grc = 1'b1; s.rout = 1'b1; end
                s.z_in = 1'b1;
              end
              3'd2: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
              default: ;
            endcase
            C_UNARY: case (step_q)
              3'd0: begin s.grb = 1'b1; s.rout = 1'b1; s.z_in = 1'b1; end
              3'd1: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
              default: ;
            endcase
            C_MULDIV: case (step_q)
              3'd0: begin s.gra = 1'b1; s.rout = 1'b1; s.y_in = 1'b1; end
              3'd1: begin s.grb = 1'b1; s.rout = 1'b1; s.z_in = 1'b1; end
              3'd2: begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
              3'd3: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
              default: ;
            endcase
            C_LD, C_LDI, C_ST: case (step_q)
              3'd0: begin s.grb = 1'b1; s.baout = 1'b1; s.y_in = 1'b1; end
              3'd1: begin s.c_out = 1'b1; s.z_in = 1'b1; end
              3'd2: begin
                s.zlow_out = 1'b1;
                if (op_class == C_LDI) begin s.gra = 1'b1; s.rin = 1'b1; end
                else s.mar_in = 1'b1;
              end
              3'd3: begin
                if (op_class == C_LD) begin
                  s.ram_read = 1'b1;
                  if (MEM_WAIT == 0) begin s.read = 1'b1; s.mdr_in = 1'b1; end
                end else if (op_class == C_ST) begin
                  s.gra = 1'b1; s.rout = 1'b1; s.mdr_in = 1'b1;
                end
              end
              3'd4: begin
                if (op_class == C_LD) begin s.mdr_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                else if (op_class == C_ST) s.ram_write = 1'b1;
              end
              default: ;
            endcase
            C_BR: case (step_q)
              3'd0: begin s.gra = 1'b1; s.rout = 1'b1; s.con_in = 1'b1; end
              3'd1: begin s.pc_out = 1'b1; s.y_in = 1'b1; end
              3'd2: begin s.c_out = 1'b1; s.z_in = 1'b1; end
              3'd3: begin s.zlow_out = 1'b1; s.pc_in = CON_out; end
              default: ;
            endcase
            C_JR:   begin s.gra = 1'b1; s.rout = 1'b1; s.pc_in = 1'b1; end
            C_JAL: begin
              if (step_q == 3'd0) begin s.pc_out = 1'b1; s.grb = 1'b1; s.rin = 1'b1; end
              else begin s.gra = 1'b1; s.rout = 1'b1; s.pc_in = 1'b1; end
            end
            C_IN:   begin s.inport_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            C_OUT:  begin s.gra = 1'b1; s.rout = 1'b1; s.outport_in = 1'b1; end
            C_MFHI: begin s.hi_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            C_MFLO: begin s.lo_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            C_ILL:  illegal = (step_q == 3'd0);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign run = run_q;
  assign {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, Read, OutPort_in} =
         {s.pc_in, s.ir_in, s.y_in, s.z_in, s.hi_in, s.lo_in, s.mar_in, s.mdr_in, s.read, s.outport_in};
  assign {PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out} =
         {s.pc_out, s.zhigh_out, s.zlow_out, s.hi_out, s.lo_out, s.mdr_out, s.inport_out, s.c_out};
  assign {RAM_read, RAM_write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, IncPC} =
         {s.ram_read, s.ram_write, s.gra, s.grb, s.grc, s.rin, s.rout, s.baout, s.con_in, s.inc_pc};

endmodule
